mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_array.sv | 27 ++
 rtl/mem_bus_responder.sv | 155 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory bus responder: address map, FSM states, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  // Address map. Both regions are 4 KB and 4 KB-aligned, so the top nibble selects the region.
  localparam logic [15:0] RAM_BASE     = 16'h0000;
  localparam logic [15:0] RAM_LAST     = 16'h0FFF;
  localparam logic [15:0] ROM_BASE     = 16'hF000;
  localparam logic [15:0] ROM_LAST     = 16'hFFFF;
  localparam logic [15:0] MAILBOX_ADDR = 16'h0042;

  // Default mailbox value that signals a passing test.
  localparam logic [7:0] PASS_CODE_DEFAULT = 8'hCF;

  // Read value returned for addresses outside RAM and ROM.
  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_ROM,
    REGION_NONE
  } region_t;

  // Request captured at the accept edge and held until the response.
  typedef struct packed {
    logic        rw;     // 1 = read, 0 = write
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  // Classify a byte address into its region.
  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr[15:12] == RAM_BASE[15:12]) begin
      return REGION_RAM;
    end
    if (addr[15:12] == ROM_BASE[15:12]) begin
      return REGION_ROM;
    end
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for the responder: 4 KB RAM (one write port) and 4 KB ROM, both read asynchronously.
// Latency: reads combinational from idx; RAM write lands on the ph2 edge where ram_we is high.
// Backpressure: none; the caller decides when to write.
module mem_array (
  input  logic        ph2,
  input  logic        ram_we,
  input  logic [11:0] idx,
  input  logic [7:0]  wdata,
  output logic [7:0]  ram_rdata,
  output logic [7:0]  rom_rdata
);

  // ram and rom are reached hierarchically for preload and inspection; reset never touches them.
  logic [7:0] ram [0:4095];
  logic [7:0] rom [0:4095];

  // RAM write port; ROM has no write path in hardware.
  always_ff @(posedge ph2) begin
    if (ram_we) begin
      ram[idx] <= wdata;
    end
  end

  assign ram_rdata = ram[idx];
  assign rom_rdata = rom[idx];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus responder: RAM/ROM/unmapped decode with optional test-status mailbox (MEM_STATUS_MONITOR_EN).
// Latency: resp_ready rises WAIT_CYCLES+1 cycles after the accept edge; one request per WAIT_CYCLES+2 cycles.
// Backpressure: no request-side ready; requests are only sampled in IDLE and the requester holds until resp_ready.
module mem_bus_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  PASS_CODE   = PASS_CODE_DEFAULT
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        resp_ready,
  output logic [7:0]  resp_data,
  output logic        bus_err,
  output logic        status_valid,
  output logic        status_pass
);

  // Wait-state count as loaded into the 4-bit counter (legal range 0..15).
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  req_t       lat;
  region_t    lat_region;
  logic       accept;
  logic       commit;
  logic       commit_en;
  logic       ram_we;
  logic       wr_fault;
  logic [7:0] ram_rdata;
  logic [7:0] rom_rdata;
  logic [7:0] rd_mux;

  // State register; reset wins over everything, aborting any request in flight.
  always_ff @(posedge ph2) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, complete in RESP.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          accept    = 1'b1;
          state_nxt = (WAIT_LOAD != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A reset landing on the RESP edge must suppress the write and the response.
  assign commit_en  = commit && !reset;
  assign lat_region = decode_region(lat.addr);
  assign ram_we     = commit_en && !lat.rw && (lat_region == REGION_RAM);
  assign wr_fault   = commit_en && !lat.rw && (lat_region != REGION_RAM);

  // Request latch and wait counter; bus inputs are only looked at on the accept edge.
  always_ff @(posedge ph2) begin
    if (reset) begin
      cnt <= 4'd0;
      lat <= '0;
    end else if (accept) begin
      cnt <= WAIT_LOAD;
      lat <= '{rw: cpu_rw, addr: cpu_addr, wdata: cpu_wdata};
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  mem_array u_mem (
    .ph2       (ph2),
    .ram_we    (ram_we),
    .idx       (lat.addr[11:0]),
    .wdata     (lat.wdata),
    .ram_rdata (ram_rdata),
    .rom_rdata (rom_rdata)
  );

  // Read data select by region of the latched address.
  always_comb begin
    rd_mux = UNMAPPED_DATA;
    unique case (lat_region)
      REGION_RAM:  rd_mux = ram_rdata;
      REGION_ROM:  rd_mux = rom_rdata;
      default:     rd_mux = UNMAPPED_DATA;
    endcase
  end

  // Response registers: one-cycle resp_ready pulse, read data alongside it, sticky write-fault flag.
  always_ff @(posedge ph2) begin
    if (reset) begin
      resp_ready <= 1'b0;
      resp_data  <= 8'h00;
      bus_err    <= 1'b0;
    end else begin
      resp_ready <= commit;
      resp_data  <= (commit && lat.rw) ? rd_mux : 8'h00;
      if (wr_fault) begin
        bus_err <= 1'b1;
      end
    end
  end

`ifdef MEM_STATUS_MONITOR_EN
  logic mbox_wr;

  // Only writes that actually land in RAM at the mailbox address update the status.
  assign mbox_wr = ram_we && (lat.addr == MAILBOX_ADDR);

  // Mailbox monitor: valid is sticky, pass follows the most recent mailbox write.
  always_ff @(posedge ph2) begin
    if (reset) begin
      status_valid <= 1'b0;
      status_pass  <= 1'b0;
    end else if (mbox_wr) begin
      status_valid <= 1'b1;
      status_pass  <= (lat.wdata == PASS_CODE);
    end
  end
`else
  // Monitor absent: the mailbox address is plain RAM and the status outputs are tied low.
  assign status_valid = 1'b0;
  assign status_pass  = 1'b0;

  // PASS_CODE has no consumer in this build.
  logic unused_pass_code;
  assign unused_pass_code = ^PASS_CODE;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with WAIT_CYCLES=0 (index 0), one with 3 (index 1).
// Latency: checks resp_ready timing against WAIT_CYCLES+1 and back-to-back period WAIT_CYCLES+2.
// Backpressure: requester holds each request until resp_ready, as the bus protocol expects.
module tb_mem_bus_responder;

`ifdef MEM_STATUS_MONITOR_EN
  localparam logic MON = 1'b1;
`else
  localparam logic MON = 1'b0;
`endif

  logic       ph2 = 1'b0;
  logic       reset;
  logic       req   [2];
  logic       rw    [2];
  logic [15:0] addr [2];
  logic [7:0] wdata [2];
  logic       rr    [2];
  logic [7:0] rd    [2];
  logic       be    [2];
  logic       sv    [2];
  logic       sp    [2];

  int errors = 0;
  int checks = 0;

  always #5 ph2 = ~ph2;

  mem_bus_responder #(.WAIT_CYCLES(0)) dut0 (
    .ph2(ph2), .reset(reset), .cpu_req(req[0]), .cpu_rw(rw[0]), .cpu_addr(addr[0]),
    .cpu_wdata(wdata[0]), .resp_ready(rr[0]), .resp_data(rd[0]), .bus_err(be[0]),
    .status_valid(sv[0]), .status_pass(sp[0])
  );

  mem_bus_responder #(.WAIT_CYCLES(3)) dut3 (
    .ph2(ph2), .reset(reset), .cpu_req(req[1]), .cpu_rw(rw[1]), .cpu_addr(addr[1]),
    .cpu_wdata(wdata[1]), .resp_ready(rr[1]), .resp_data(rd[1]), .bus_err(be[1]),
    .status_valid(sv[1]), .status_pass(sp[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge ph2);
    #1;
  endtask

  function automatic logic [7:0] rom_pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // One request on instance k; lat = cycles from accept edge to resp_ready (-1 on timeout).
  task automatic xact(input int k, input logic rw_i, input logic [15:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] data);
    int n;
    n    = 0;
    lat  = -1;
    data = 8'hxx;
    req[k] = 1'b1; rw[k] = rw_i; addr[k] = a; wdata[k] = d;
    while (n < 40) begin
      step();
      n++;
      if (rr[k]) begin
        lat  = n - 1;
        data = rd[k];
        break;
      end
    end
    req[k] = 1'b0;
    step();
  endtask

  // Reads with cpu_req held high; address changes as soon as each response is seen.
  task automatic b2b(input int k, input int wcy, input logic [3:0][15:0] a, input logic [3:0][7:0] e);
    int n;
    int got;
    int last;
    n = 0; got = 0; last = 0;
    req[k] = 1'b1; rw[k] = 1'b1; addr[k] = a[0];
    while (got < 4 && n < 200) begin
      step();
      n++;
      if (rr[k]) begin
        if (got == 0) check("b2b_first_latency", n - 1, wcy + 1);
        else          check("b2b_period", n - last, wcy + 2);
        check("b2b_data", rd[k], e[got]);
        last = n;
        got++;
        if (got < 4) addr[k] = a[got];
        else         req[k] = 1'b0;
      end
    end
    check("b2b_count", got, 4);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] data;
    logic       seen;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; rw[k] = 1'b0; addr[k] = 16'h0000; wdata[k] = 8'h00;
    end
    for (int i = 0; i < 4096; i++) begin
      dut0.u_mem.rom[i] = rom_pat(i);
      dut3.u_mem.rom[i] = rom_pat(i);
      dut0.u_mem.ram[i] = 8'h00;
      dut3.u_mem.ram[i] = 8'h00;
    end
    dut0.u_mem.rom[4092] = 8'h00;
    dut3.u_mem.rom[4092] = 8'h00;
    dut3.u_mem.ram[32]   = 8'h77;
    dut3.u_mem.ram[4095] = 8'h9C;

    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check("reset_resp_ready", rr[k], 1'b0);
      check("reset_resp_data", rd[k], 8'h00);
      check("reset_bus_err", be[k], 1'b0);
      check("reset_status_valid", sv[k], 1'b0);
      check("reset_status_pass", sp[k], 1'b0);
    end
    reset = 1'b0;
    step();

    // Zero wait states: ROM reads
    xact(0, 1'b1, 16'hFFFC, 8'h00, lat, data);
    check("w0_rom_latency", lat, 1);
    check("w0_rom_data", data, 8'h00);
    check("w0_pulse_width", rr[0], 1'b0);
    xact(0, 1'b1, 16'hF001, 8'h00, lat, data);
    check("w0_rom1_data", data, 8'h0A);

    // Three wait states: RAM write then read-back
    xact(1, 1'b0, 16'h0010, 8'h5A, lat, data);
    check("w3_wr_latency", lat, 4);
    check("w3_wr_ram16", dut3.u_mem.ram[16], 8'h5A);
    check("w3_wr_no_err", be[1], 1'b0);
    xact(1, 1'b1, 16'h0010, 8'h00, lat, data);
    check("w3_rd_latency", lat, 4);
    check("w3_rd_data", data, 8'h5A);
    check("w3_pulse_width", rr[1], 1'b0);

    // Mailbox
    xact(1, 1'b0, 16'h0042, 8'hCF, lat, data);
    check("mbox_pass_ram66", dut3.u_mem.ram[66], 8'hCF);
    check("mbox_pass_valid", sv[1], MON);
    check("mbox_pass_pass", sp[1], MON);
    xact(1, 1'b0, 16'h0042, 8'h00, lat, data);
    check("mbox_fail_ram66", dut3.u_mem.ram[66], 8'h00);
    check("mbox_fail_valid", sv[1], MON);
    check("mbox_fail_pass", sp[1], 1'b0);

    // ROM write: discarded, flagged, still completes
    xact(1, 1'b0, 16'hF000, 8'h11, lat, data);
    check("rom_wr_latency", lat, 4);
    check("rom_wr_bus_err", be[1], 1'b1);
    check("rom_wr_rom0", dut3.u_mem.rom[0], 8'h03);
    xact(1, 1'b1, 16'hF000, 8'h00, lat, data);
    check("rom_rd_after_wr", data, 8'h03);

    // Unmapped and RAM-edge reads
    xact(1, 1'b1, 16'h8000, 8'h00, lat, data);
    check("unmapped_latency", lat, 4);
    check("unmapped_data", data, 8'hFF);
    xact(1, 1'b1, 16'h1000, 8'h00, lat, data);
    check("past_ram_data", data, 8'hFF);
    xact(1, 1'b1, 16'h0FFF, 8'h00, lat, data);
    check("ram_last_data", data, 8'h9C);
    check("bus_err_sticky", be[1], 1'b1);

    // Reset during WAIT aborts the write
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 16'h0020; wdata[1] = 8'hEE;
    step();
    step();
    reset = 1'b1; req[1] = 1'b0;
    seen = 1'b0;
    repeat (3) begin step(); if (rr[1]) seen = 1'b1; end
    reset = 1'b0;
    repeat (6) begin step(); if (rr[1]) seen = 1'b1; end
    check("abort_wait_no_resp", seen, 1'b0);
    check("abort_wait_ram32", dut3.u_mem.ram[32], 8'h77);
    check("abort_wait_resp_data", rd[1], 8'h00);
    check("abort_wait_bus_err", be[1], 1'b0);
    check("abort_wait_status_valid", sv[1], 1'b0);
    check("abort_wait_status_pass", sp[1], 1'b0);

    // Reset landing on the RESP edge (zero wait states) aborts the write
    req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 16'h0030; wdata[0] = 8'hEE;
    step();
    reset = 1'b1; req[0] = 1'b0;
    seen = 1'b0;
    repeat (2) begin step(); if (rr[0]) seen = 1'b1; end
    reset = 1'b0;
    repeat (4) begin step(); if (rr[0]) seen = 1'b1; end
    check("abort_resp_no_resp", seen, 1'b0);
    check("abort_resp_ram48", dut0.u_mem.ram[48], 8'h00);

    // Back-to-back reads, requests held high
    b2b(1, 3, {16'h8000, 16'hF001, 16'h0042, 16'h0010}, {8'hFF, 8'h0A, 8'h00, 8'h5A});
    b2b(0, 0, {16'hFFFC, 16'h8000, 16'hF001, 16'hFFFC}, {8'h00, 8'hFF, 8'h0A, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
